// File: rtl/operand_latch.sv
// operand_latch
//   Decode-to-execute pipeline register. It sits just after the forwarding
//   control stage. For each of the d/s/t operands it picks the youngest
//   forwarding stage that hits, or the register-file value when no stage
//   hits. It latches the resolved operands with the micro-instruction and
//   presents them to execute over a valid/ready handshake. It also owns the
//   load-use interlock: when the winning forward source is a load whose data
//   is not ready yet, the block inserts a bubble.
//
// Optional feature macro: OPERAND_LATCH_STATS_EN
//   When the macro is defined, the block adds two 32-bit wrapping counters:
//   stat_fwd_hits and stat_lu_stalls.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   dec_valid/ready   handshake with decode
//   dec_miinst        decoded micro-instruction (MIINST_W bits)
//   rf_d/s/t          register-file read values
//   fwd_sig_from[i]   hit flags of stage i, packed {d,s,t} (bit2=d, bit0=t)
//   fwd_val_from[i]   result value of stage i
//   pos_is_load[i]    stage i holds a load whose result is not yet valid
//   flush             kill the held and the incoming instruction
//   exe_valid/ready   handshake with execute
//   exe_miinst        latched micro-instruction
//   exe_d/s/t         latched resolved operands
module operand_latch #(
  parameter int POST_DEC_LD = 3,
  parameter int REG_W       = 64,
  parameter int MIINST_W    = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                dec_valid,
  output logic                                dec_ready,
  input  logic [MIINST_W-1:0]                 dec_miinst,
  input  logic [REG_W-1:0]                    rf_d,
  input  logic [REG_W-1:0]                    rf_s,
  input  logic [REG_W-1:0]                    rf_t,
  input  logic [POST_DEC_LD-1:0][2:0]         fwd_sig_from,
  input  logic [POST_DEC_LD-1:0][REG_W-1:0]   fwd_val_from,
  input  logic [POST_DEC_LD-1:0]              pos_is_load,
  input  logic                                flush,
  input  logic                                exe_ready,
  output logic                                exe_valid,
  output logic [MIINST_W-1:0]                 exe_miinst,
  output logic [REG_W-1:0]                    exe_d,
  output logic [REG_W-1:0]                    exe_s,
  output logic [REG_W-1:0]                    exe_t
`ifdef OPERAND_LATCH_STATS_EN
  ,
  output logic [31:0]                         stat_fwd_hits,
  output logic [31:0]                         stat_lu_stalls
`endif
);

  typedef enum logic [1:0] {EMPTY, FULL, STALL} state_t;

  state_t               state_q;
  logic [2:0]           stall_cnt_q;
  logic                 exe_valid_q;
  logic [MIINST_W-1:0]  exe_miinst_q;
  logic [REG_W-1:0]     exe_d_q, exe_s_q, exe_t_q;

  // The operand fields are indexed 0=d, 1=s, 2=t.
  logic [REG_W-1:0]     rf_vec  [3];
  logic [REG_W-1:0]     sel_val [3];
  logic [2:0]           hit_vec;
  logic [2:0]           ld_vec;
  logic                 lu;
  logic                 accept;

  assign rf_vec[0] = rf_d;
  assign rf_vec[1] = rf_s;
  assign rf_vec[2] = rf_t;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fld
      logic             hit;
      logic             ld;
      logic [REG_W-1:0] val;

      // The scan runs from the oldest stage to the youngest. A later write
      // overrides an earlier one, so the lowest hitting index wins. The
      // load flag belongs to that winning stage only.
      always_comb begin
        hit = 1'b0;
        ld  = 1'b0;
        val = rf_vec[gi];
        for (int i = POST_DEC_LD - 1; i >= 0; i--) begin
          if (fwd_sig_from[i][2-gi]) begin
            hit = 1'b1;
            ld  = pos_is_load[i];
            val = fwd_val_from[i];
          end
        end
      end

      assign hit_vec[gi] = hit;
      assign ld_vec[gi]  = ld;
      assign sel_val[gi] = val;
    end
  endgenerate

  assign lu        = dec_valid & (|ld_vec);
  assign dec_ready = ~lu & (~exe_valid_q | exe_ready) & ~flush;
  assign accept    = dec_valid & dec_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      stall_cnt_q  <= 3'd0;
      exe_valid_q  <= 1'b0;
      exe_miinst_q <= '0;
      exe_d_q      <= '0;
      exe_s_q      <= '0;
      exe_t_q      <= '0;
    end else if (flush) begin
      state_q     <= EMPTY;
      stall_cnt_q <= 3'd0;
      exe_valid_q <= 1'b0;
    end else if (state_q == FULL && !exe_ready) begin
      // Execute is back-pressuring. Everything holds, whatever the
      // forwarding inputs do meanwhile.
      state_q <= FULL;
    end else if (accept) begin
      state_q      <= FULL;
      stall_cnt_q  <= 3'd0;
      exe_valid_q  <= 1'b1;
      exe_miinst_q <= dec_miinst;
      exe_d_q      <= sel_val[0];
      exe_s_q      <= sel_val[1];
      exe_t_q      <= sel_val[2];
    end else if (lu) begin
      state_q     <= STALL;
      exe_valid_q <= 1'b0;
      if (state_q != STALL)
        stall_cnt_q <= 3'd1;
      else if (stall_cnt_q != 3'd7)
        stall_cnt_q <= stall_cnt_q + 3'd1;
    end else begin
      state_q     <= EMPTY;
      stall_cnt_q <= 3'd0;
      exe_valid_q <= 1'b0;
    end
  end

  assign exe_valid  = exe_valid_q;
  assign exe_miinst = exe_miinst_q;
  assign exe_d      = exe_d_q;
  assign exe_s      = exe_s_q;
  assign exe_t      = exe_t_q;

`ifdef OPERAND_LATCH_STATS_EN
  logic [31:0] fwd_hits_q, lu_stalls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_hits_q  <= 32'd0;
      lu_stalls_q <= 32'd0;
    end else begin
      if (accept && (|hit_vec))
        fwd_hits_q <= fwd_hits_q + 32'd1;
      if (state_q == STALL)
        lu_stalls_q <= lu_stalls_q + 32'd1;
    end
  end

  assign stat_fwd_hits  = fwd_hits_q;
  assign stat_lu_stalls = lu_stalls_q;
`endif

endmodule

// File: tb/tb_operand_latch.sv
module tb_operand_latch;
  localparam int N  = 3;
  localparam int W  = 64;
  localparam int MW = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                dec_valid, dec_ready;
  logic [MW-1:0]       dec_miinst;
  logic [W-1:0]        rf_d, rf_s, rf_t;
  logic [N-1:0][2:0]   fwd_sig_from;
  logic [N-1:0][W-1:0] fwd_val_from;
  logic [N-1:0]        pos_is_load;
  logic                flush, exe_ready, exe_valid;
  logic [MW-1:0]       exe_miinst;
  logic [W-1:0]        exe_d, exe_s, exe_t;
`ifdef OPERAND_LATCH_STATS_EN
  logic [31:0]         stat_fwd_hits, stat_lu_stalls;
  int unsigned         m_hits, m_stalls;
`endif

  always #5 clk = ~clk;

  operand_latch #(.POST_DEC_LD(N), .REG_W(W), .MIINST_W(MW)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_miinst(dec_miinst),
    .rf_d(rf_d), .rf_s(rf_s), .rf_t(rf_t),
    .fwd_sig_from(fwd_sig_from), .fwd_val_from(fwd_val_from),
    .pos_is_load(pos_is_load), .flush(flush), .exe_ready(exe_ready),
    .exe_valid(exe_valid), .exe_miinst(exe_miinst),
    .exe_d(exe_d), .exe_s(exe_s), .exe_t(exe_t)
`ifdef OPERAND_LATCH_STATS_EN
    , .stat_fwd_hits(stat_fwd_hits), .stat_lu_stalls(stat_lu_stalls)
`endif
  );

  typedef struct {
    logic [MW-1:0] mi;
    logic [W-1:0]  d, s, t;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic m_valid;   // model: an instruction is held for execute
  logic m_stall;   // model: currently in the load-use bubble

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The reference operand for field f (0=d,1=s,2=t) is the value of the
  // first hitting stage, counted from the youngest, else the register file.
  function automatic logic [W-1:0] resolve(input int f);
    for (int i = 0; i < N; i++)
      if (fwd_sig_from[i][2-f]) return fwd_val_from[i];
    return (f == 0) ? rf_d : (f == 1) ? rf_s : rf_t;
  endfunction

  function automatic logic model_lu();
    if (!dec_valid) return 1'b0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++)
        if (fwd_sig_from[i][2-f]) begin
          if (pos_is_load[i]) return 1'b1;
          break;
        end
    return 1'b0;
  endfunction

  // The monitor compares the held output against the oldest scoreboard
  // entry on every valid cycle. The entry leaves the scoreboard only when
  // execute takes it.
  always @(negedge clk) begin
    if (!reset && exe_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_exe_valid", 1, 0);
      end else begin
        check("exe_miinst", exe_miinst, sb[0].mi);
        check("exe_d", exe_d, sb[0].d);
        check("exe_s", exe_s, sb[0].s);
        check("exe_t", exe_t, sb[0].t);
        $display("exe txn mi=%h d=%h s=%h t=%h ready=%0b", exe_miinst, exe_d, exe_s, exe_t, exe_ready);
        if (exe_ready) void'(sb.pop_front());
      end
    end
  end

  // This task runs one cycle. The inputs are already driven. It checks the
  // combinational outputs, advances the model and then returns just after
  // the next rising edge.
  task automatic step();
    logic lu, rdy, acc, any;
    exp_t e;
    @(negedge clk);
    lu  = model_lu();
    rdy = !lu && (!m_valid || exe_ready) && !flush;
    acc = dec_valid && rdy;
    check("dec_ready", dec_ready, rdy);
    check("exe_valid", exe_valid, m_valid);
`ifdef OPERAND_LATCH_STATS_EN
    check("stat_lu_stalls", stat_lu_stalls, m_stalls);
    check("stat_fwd_hits", stat_fwd_hits, m_hits);
    if (m_stall) m_stalls++;
`endif
    #1;
    any = |fwd_sig_from;
    if (flush) begin
      if (m_valid && !exe_ready && sb.size() > 0) void'(sb.pop_front());
      m_valid = 0; m_stall = 0;
    end else if (m_valid && !exe_ready) begin
      // The held instruction stays in place.
    end else if (acc) begin
      e.mi = dec_miinst; e.d = resolve(0); e.s = resolve(1); e.t = resolve(2);
      sb.push_back(e);
      m_valid = 1; m_stall = 0;
`ifdef OPERAND_LATCH_STATS_EN
      if (any) m_hits++;
`endif
    end else if (lu) begin
      m_valid = 0; m_stall = 1;
    end else begin
      m_valid = 0; m_stall = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_miinst = '0; rf_d = '0; rf_s = '0; rf_t = '0;
    fwd_sig_from = '0; fwd_val_from = '0; pos_is_load = '0;
    flush = 0; exe_ready = 1;
  endtask

  task automatic model_reset();
    sb.delete(); m_valid = 0; m_stall = 0;
`ifdef OPERAND_LATCH_STATS_EN
    m_hits = 0; m_stalls = 0;
`endif
  endtask

  task automatic fill_held(input logic [MW-1:0] mi);
    idle(); dec_valid = 1; dec_miinst = mi; rf_d = 64'h1234; exe_ready = 0;
    step();
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_exe_valid", exe_valid, 0);
    check("rst_exe_miinst", exe_miinst, 0);
    check("rst_exe_d", exe_d, 0);
    check("rst_exe_s", exe_s, 0);
    check("rst_exe_t", exe_t, 0);
    reset = 0;

    // Two instructions without hits stream back to back with no bubble.
    dec_valid = 1; dec_miinst = 32'h101; rf_s = 64'h11; rf_t = 64'h22; exe_ready = 1;
    step();
    dec_miinst = 32'h102;
    step();
    idle(); step();

    // Stages 0 and 2 both hit the s field. Stage 0 wins.
    dec_valid = 1; dec_miinst = 32'h201;
    fwd_sig_from[0] = 3'b010; fwd_val_from[0] = 64'hAA;
    fwd_sig_from[2] = 3'b010; fwd_val_from[2] = 64'hBB;
    step();
    idle(); step();

    // Load-use hazard gives one bubble. The producer then moves to stage 1.
    dec_valid = 1; dec_miinst = 32'h301;
    fwd_sig_from[0] = 3'b001; fwd_val_from[0] = 64'h99; pos_is_load = 3'b001;
    step();
    fwd_sig_from = '0; pos_is_load = '0;
    fwd_sig_from[1] = 3'b001; fwd_val_from[1] = 64'h5;
    step();
    idle(); step();

    // Execute back-pressures for three cycles while the forwarding inputs
    // toggle. The next instruction is then taken without a bubble.
    fill_held(32'h401);
    dec_miinst = 32'h402; rf_s = 64'h77;
    for (int k = 0; k < 3; k++) begin
      fwd_sig_from[0] = 3'($urandom); fwd_val_from[0] = {$urandom, $urandom};
      step();
    end
    exe_ready = 1;
    step();
    idle(); step();

    // A flush while FULL with dec_valid, then a flush while in STALL.
    fill_held(32'h501);
    dec_miinst = 32'h502; flush = 1;
    step();
    idle(); step();
    dec_valid = 1; dec_miinst = 32'h503;
    fwd_sig_from[1] = 3'b100; pos_is_load = 3'b010;
    step(); step();
    flush = 1;
    step();
    idle(); step();

    // Asynchronous reset between clock edges while FULL.
    fill_held(32'h601);
    #2 reset = 1;
    #1;
    check("async_rst_full_valid", exe_valid, 0);
    check("async_rst_full_mi", exe_miinst, 0);
    model_reset();
    @(posedge clk); #1 reset = 0; idle();

    // Asynchronous reset between clock edges after two cycles in STALL.
    dec_valid = 1; dec_miinst = 32'h701;
    fwd_sig_from[0] = 3'b100; pos_is_load = 3'b001;
    step(); step(); step();
`ifdef OPERAND_LATCH_STATS_EN
    check("stalls_before_rst", stat_lu_stalls, 2);
`endif
    #2 reset = 1;
    #1;
    check("async_rst_stall_valid", exe_valid, 0);
`ifdef OPERAND_LATCH_STATS_EN
    check("stalls_after_rst", stat_lu_stalls, 0);
`endif
    model_reset();
    @(posedge clk); #1 reset = 0; idle();
    dec_valid = 1; dec_miinst = 32'h702;
    step();
    idle(); step();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      dec_valid  = ($urandom_range(0, 3) != 0);
      dec_miinst = $urandom;
      rf_d = {$urandom, $urandom}; rf_s = {$urandom, $urandom}; rf_t = {$urandom, $urandom};
      for (int i = 0; i < N; i++) begin
        fwd_sig_from[i] = $urandom_range(0, 1) ? 3'($urandom) : 3'b000;
        fwd_val_from[i] = {$urandom, $urandom};
        pos_is_load[i]  = ($urandom_range(0, 5) == 0);
      end
      flush     = ($urandom_range(0, 19) == 0);
      exe_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    idle();
    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
